// File: rtl/alu_seq_pkg.sv
// Shared constants for the nibble-serial ALU: opcode values, FSM state encoding and
// the decimal-adjust constants used by the digit slice.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_LSR = 4'd5,
        OP_ASL = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Largest legal decimal digit and the correction added/subtracted past it
    localparam int unsigned DEC_LIMIT = 9;
    localparam int unsigned DEC_ADJ   = 6;

endpackage

// File: rtl/alu_seq_digit.sv
// One-nibble add/subtract slice with optional decimal adjust.
// Decimal correction exists only when ALU_SEQ_BCD_EN is defined; otherwise bcd is ignored.
module alu_seq_digit
    import alu_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    input  logic       sub,
    input  logic       bcd,
    output logic [3:0] digit,
    output logic       cout,
    output logic       bin_cout,
    output logic       msb_cin
);

    logic [3:0] y_eff;
    logic [4:0] raw;

    assign y_eff    = sub ? ~y : y;
    assign raw      = {1'b0, x} + {1'b0, y_eff} + {4'd0, cin};
    assign bin_cout = raw[4];
    // Carry into bit 3 recovered from the sum bit; feeds signed overflow of the top digit
    assign msb_cin  = x[3] ^ y_eff[3] ^ raw[3];

`ifdef ALU_SEQ_BCD_EN
    // Decimal adjust: ADC corrects sums above 9, SBC corrects on a digit borrow
    always_comb begin
        digit = raw[3:0];
        cout  = raw[4];
        if (bcd && !sub && (raw > 5'(DEC_LIMIT))) begin
            digit = raw[3:0] + 4'(DEC_ADJ);
            cout  = 1'b1;
        end else if (bcd && sub && !raw[4]) begin
            digit = raw[3:0] - 4'(DEC_ADJ);
        end
    end
`else
    logic unused_bcd;
    assign unused_bcd = bcd;

    // Binary only: no correction logic
    always_comb begin
        digit = raw[3:0];
        cout  = raw[4];
    end
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked 6502-style ALU. ADC/SBC run one nibble per clock, digit 0 on the accept edge;
// logic, shift and illegal ops complete on the accept edge.
// Optional decimal mode: define ALU_SEQ_BCD_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             bcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             v,
    output logic             z,
    output logic             c,
    output logic             hc
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             bcd_q, bcd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d, hc_q, hc_d;

    logic             bcd_in;
    logic [CW+1:0]    dsel;
    logic [3:0]       dx, dy, dig;
    logic             dci, dsub, dbcd, dcout, dbin, dmsb;
    logic [WIDTH-1:0] arith_res, quick_res;
    logic             quick_c, is_arith;

`ifdef ALU_SEQ_BCD_EN
    assign bcd_in = bcd;
`else
    logic unused_bcd;
    assign unused_bcd = bcd;
    assign bcd_in     = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign n         = n_q;
    assign v         = v_q;
    assign z         = z_q;
    assign c         = c_q;
    assign hc        = hc_q;

    assign is_arith = (op == OP_ADC) || (op == OP_SBC);
    assign dsel     = (state_q == S_CALC) ? {cnt_q, 2'b00} : '0;

    // Digit operands: raw inputs on the accept cycle, registered operands while in CALC
    always_comb begin
        if (state_q == S_CALC) begin
            dx   = a_q[dsel +: 4];
            dy   = b_q[dsel +: 4];
            dci  = carry_q;
            dsub = (op_q == OP_SBC);
            dbcd = bcd_q;
        end else begin
            dx   = a[3:0];
            dy   = b[3:0];
            dci  = cin;
            dsub = (op == OP_SBC);
            dbcd = bcd_in;
        end
    end

    alu_seq_digit u_digit (
        .x        (dx),
        .y        (dy),
        .cin      (dci),
        .sub      (dsub),
        .bcd      (dbcd),
        .digit    (dig),
        .cout     (dcout),
        .bin_cout (dbin),
        .msb_cin  (dmsb)
    );

    // Partial arithmetic result with the current digit merged in (cleared on accept)
    always_comb begin
        arith_res = (state_q == S_CALC) ? result_q : '0;
        arith_res[dsel +: 4] = dig;
    end

    // Single-cycle logic/shift results; illegal ops yield zero with c = 0
    always_comb begin
        quick_res = '0;
        quick_c   = 1'b0;
        case (op)
            OP_AND:  begin quick_res = a & b; quick_c = cin; end
            OP_ORA:  begin quick_res = a | b; quick_c = cin; end
            OP_EOR:  begin quick_res = a ^ b; quick_c = cin; end
            OP_LSR:  begin quick_res = {1'b0, a[WIDTH-1:1]}; quick_c = a[0];       end
            OP_ASL:  begin quick_res = {a[WIDTH-2:0], 1'b0}; quick_c = a[WIDTH-1]; end
            OP_ROL:  begin quick_res = {a[WIDTH-2:0], cin};  quick_c = a[WIDTH-1]; end
            OP_ROR:  begin quick_res = {cin, a[WIDTH-1:1]};  quick_c = a[0];       end
            default: begin quick_res = '0; quick_c = 1'b0; end
        endcase
    end

    // Next-state, operand capture and flag update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        bcd_d    = bcd_q;
        result_d = result_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;
        c_d      = c_q;
        hc_d     = hc_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = op;
                    bcd_d = bcd_in;
                    if (is_arith) begin
                        result_d = arith_res;
                        carry_d  = dcout;
                        hc_d     = dcout;
                        cnt_d    = CW'(1);
                        if (NIB == 1) begin
                            c_d     = dcout;
                            v_d     = dmsb ^ dbin;
                            n_d     = arith_res[WIDTH-1];
                            z_d     = (arith_res == '0);
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        result_d = quick_res;
                        c_d      = quick_c;
                        v_d      = 1'b0;
                        hc_d     = 1'b0;
                        n_d      = quick_res[WIDTH-1];
                        z_d      = (quick_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_CALC: begin
                result_d = arith_res;
                carry_d  = dcout;
                if (cnt_q == CW'(NIB - 1)) begin
                    c_d     = dcout;
                    v_d     = dmsb ^ dbin;
                    n_d     = arith_res[WIDTH-1];
                    z_d     = (arith_res == '0);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            bcd_q    <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            hc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            bcd_q    <= bcd_d;
            result_q <= result_d;
            n_q      <= n_d;
            v_q      <= v_d;
            z_q      <= z_d;
            c_q      <= c_d;
            hc_q     <= hc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for function/handshake and a 16-bit
// instance for mid-operation reset. Decimal expectations follow ALU_SEQ_BCD_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk, rst, rst16;
    int   n_cmp, n_err, lat;

    logic       in_valid8, rdy8, ov8, out_ready8, cin8, bcd8;
    logic [3:0] op8;
    logic [7:0] a8, b8, res8;
    logic       n8, v8, z8, c8, hc8;

    logic        in_valid16, rdy16, ov16, out_ready16, cin16, bcd16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16;
    logic        n16, v16, z16, c16, hc16;

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy8), .op(op8),
        .a(a8), .b(b8), .cin(cin8), .bcd(bcd8), .out_valid(ov8), .out_ready(out_ready8),
        .result(res8), .n(n8), .v(v8), .z(z8), .c(c8), .hc(hc8)
    );

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(rdy16), .op(op16),
        .a(a16), .b(b16), .cin(cin16), .bcd(bcd16), .out_valid(ov16), .out_ready(out_ready16),
        .result(res16), .n(n16), .v(v16), .z(z16), .c(c16), .hc(hc16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 8-bit unit; lat counts edges from accept (inclusive) to out_valid
    task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic bc);
        op8 = o; a8 = x; b8 = y; cin8 = ci; bcd8 = bc; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci);
        op16 = o; a16 = x; b16 = y; cin16 = ci; bcd16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({rdy8, ov8, res8, n8, v8, z8, c8, hc8} !== {2'b10, 8'h00, 5'b00000}) begin
            n_err++;
            $display("FAIL reset8: got rdy/ov=%b%b res=%h flags=%b, want 10 00 00000",
                     rdy8, ov8, res8, {n8, v8, z8, c8, hc8});
        end
        n_cmp++;
        if ({rdy16, ov16, res16, n16, v16, z16, c16, hc16} !== {2'b10, 16'h0, 5'b0}) begin
            n_err++;
            $display("FAIL reset16: got rdy/ov=%b%b res=%h, want 10 0000", rdy16, ov16, res16);
        end
    endtask

    task automatic test_adc_bin();
        run8(OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0);
        n_cmp++;
        if (lat !== 2) begin
            n_err++; $display("FAIL adc_lat: got %0d want 2", lat);
        end
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'hA0, 5'b11000}) begin
            n_err++;
            $display("FAIL adc_50_50: got %h nvzc_hc=%b want a0 11000", res8,
                     {n8, v8, z8, c8, hc8});
        end
        tick();
        run8(OP_ADC, 8'hFF, 8'h01, 1'b0, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h00, 5'b00111}) begin
            n_err++;
            $display("FAIL adc_ff_01: got %h nvzc_hc=%b want 00 00111", res8,
                     {n8, v8, z8, c8, hc8});
        end
        tick();
        run8(OP_SBC, 8'h50, 8'h30, 1'b1, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h20, 5'b00011}) begin
            n_err++;
            $display("FAIL sbc_50_30: got %h nvzc_hc=%b want 20 00011", res8,
                     {n8, v8, z8, c8, hc8});
        end
        tick();
    endtask

    task automatic test_bcd();
        logic [7:0] e_res2, e_res3;
        logic [3:0] e_f2, e_f3;
`ifdef ALU_SEQ_BCD_EN
        e_res2 = 8'h05; e_f2 = 4'b0011;
        e_res3 = 8'h91; e_f3 = 4'b1001;
`else
        e_res2 = 8'h9F; e_f2 = 4'b1000;
        e_res3 = 8'hF1; e_f3 = 4'b1001;
`endif
        run8(OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1);
        n_cmp++;
        if ({res8, n8, z8, c8, hc8} !== {e_res2, e_f2} || lat !== 2) begin
            n_err++;
            $display("FAIL bcd_adc: got %h nzc_hc=%b lat=%0d want %h %b lat=2", res8,
                     {n8, z8, c8, hc8}, lat, e_res2, e_f2);
        end
        tick();
        run8(OP_SBC, 8'h12, 8'h21, 1'b1, 1'b1);
        n_cmp++;
        if ({res8, n8, z8, c8, hc8} !== {e_res3, e_f3}) begin
            n_err++;
            $display("FAIL bcd_sbc: got %h nzc_hc=%b want %h %b", res8, {n8, z8, c8, hc8},
                     e_res3, e_f3);
        end
        tick();
    endtask

    task automatic test_logic();
        run8(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h30, 5'b00010} || lat !== 1) begin
            n_err++;
            $display("FAIL and: got %h flags=%b lat=%0d want 30 00010 lat=1", res8,
                     {n8, v8, z8, c8, hc8}, lat);
        end
        tick();
        run8(OP_EOR, 8'hAA, 8'hAA, 1'b0, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h00, 5'b00100}) begin
            n_err++;
            $display("FAIL eor: got %h flags=%b want 00 00100", res8, {n8, v8, z8, c8, hc8});
        end
        tick();
        run8(OP_ORA, 8'h0F, 8'h80, 1'b0, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h8F, 5'b10000}) begin
            n_err++;
            $display("FAIL ora: got %h flags=%b want 8f 10000", res8, {n8, v8, z8, c8, hc8});
        end
        tick();
    endtask

    task automatic test_shift();
        logic [3:0]  ops  [5] = '{OP_ROR, OP_LSR, OP_ASL, OP_ROL, OP_ROL};
        logic [7:0]  ain  [5] = '{8'h01, 8'h01, 8'h81, 8'h80, 8'h40};
        logic        ci   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [12:0] want [5] = '{{8'h80, 5'b10010}, {8'h00, 5'b00110}, {8'h02, 5'b00010},
                                  {8'h01, 5'b00010}, {8'h80, 5'b10000}};
        for (int i = 0; i < 5; i++) begin
            run8(ops[i], ain[i], 8'hFF, ci[i], 1'b0);
            n_cmp++;
            if ({res8, n8, v8, z8, c8, hc8} !== want[i] || lat !== 1) begin
                n_err++;
                $display("FAIL shift%0d: got %h flags=%b lat=%0d want %h %b lat=1", i, res8,
                         {n8, v8, z8, c8, hc8}, lat, want[i][12:5], want[i][4:0]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        run8(4'd9, 8'hFF, 8'hFF, 1'b1, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h00, 5'b00100} || lat !== 1) begin
            n_err++;
            $display("FAIL illegal9: got %h flags=%b lat=%0d want 00 00100 lat=1", res8,
                     {n8, v8, z8, c8, hc8}, lat);
        end
        tick();
        run8(OP_ORA, 8'hFF, 8'h00, 1'b1, 1'b0);
        tick();
        run8(4'd15, 8'h12, 8'h34, 1'b1, 1'b0);
        n_cmp++;
        if ({res8, n8, v8, z8, c8, hc8} !== {8'h00, 5'b00100}) begin
            n_err++;
            $display("FAIL illegal15: got %h flags=%b want 00 00100", res8,
                     {n8, v8, z8, c8, hc8});
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready8 = 1'b0;
        run8(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            op8 = OP_ADC; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
            tick();
            n_cmp++;
            if ({ov8, rdy8, res8, n8, v8, z8, c8, hc8} !== {2'b10, 8'h30, 5'b00010}) begin
                n_err++;
                $display("FAIL hold%0d: got ov/rdy=%b%b %h flags=%b want 10 30 00010", i, ov8,
                         rdy8, res8, {n8, v8, z8, c8, hc8});
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        n_cmp++;
        if ({ov8, rdy8} !== 2'b01) begin
            n_err++; $display("FAIL release: got ov/rdy=%b%b want 01", ov8, rdy8);
        end
        tick();
        n_cmp++;
        if ({ov8, rdy8} !== 2'b01) begin
            n_err++; $display("FAIL dropped: got ov/rdy=%b%b want 01", ov8, rdy8);
        end
    endtask

    task automatic test_back_to_back();
        run8(OP_ORA, 8'h0F, 8'hF0, 1'b0, 1'b0);
        op8 = OP_EOR; a8 = 8'hFF; b8 = 8'h0F; cin8 = 1'b1; in_valid8 = 1'b1;
        tick();
        n_cmp++;
        if ({ov8, rdy8} !== 2'b01) begin
            n_err++; $display("FAIL b2b_idle: got ov/rdy=%b%b want 01", ov8, rdy8);
        end
        tick();
        in_valid8 = 1'b0;
        n_cmp++;
        if ({ov8, res8, n8, v8, z8, c8, hc8} !== {1'b1, 8'hF0, 5'b10010}) begin
            n_err++;
            $display("FAIL b2b_eor: got ov=%b %h flags=%b want 1 f0 10010", ov8, res8,
                     {n8, v8, z8, c8, hc8});
        end
        tick();
    endtask

    task automatic test_reset_midop();
        op16 = OP_ADC; a16 = 16'h0019; b16 = 16'h0009; cin16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        n_cmp++;
        if ({ov16, rdy16, res16, hc16} !== {2'b00, 16'h0002, 1'b1}) begin
            n_err++;
            $display("FAIL pre_rst: got ov/rdy=%b%b %h hc=%b want 00 0002 1", ov16, rdy16,
                     res16, hc16);
        end
        rst16 = 1'b1;
        #1;
        n_cmp++;
        if ({ov16, rdy16, res16, n16, v16, z16, c16, hc16} !== {2'b01, 16'h0, 5'b0}) begin
            n_err++;
            $display("FAIL mid_rst: got ov/rdy=%b%b %h flags=%b want 01 0000 00000", ov16,
                     rdy16, res16, {n16, v16, z16, c16, hc16});
        end
        rst16 = 1'b0;
        tick();
        n_cmp++;
        if ({ov16, rdy16} !== 2'b01) begin
            n_err++; $display("FAIL post_rst: got ov/rdy=%b%b want 01", ov16, rdy16);
        end
        run16(OP_ADC, 16'hFFFF, 16'h0001, 1'b0);
        n_cmp++;
        if ({res16, n16, v16, z16, c16, hc16} !== {16'h0000, 5'b00111} || lat !== 4) begin
            n_err++;
            $display("FAIL adc16: got %h flags=%b lat=%0d want 0000 00111 lat=4", res16,
                     {n16, v16, z16, c16, hc16}, lat);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; lat = 0;
        rst = 1'b1; rst16 = 1'b1;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; cin8 = 1'b0; bcd8 = 1'b0;
        out_ready8 = 1'b1;
        in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; cin16 = 1'b0; bcd16 = 1'b0;
        out_ready16 = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0; rst16 = 1'b0;
        tick();
        test_adc_bin();
        test_bcd();
        test_logic();
        test_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
